// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller drives start/x/y through master; the subtractor answers through slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, x, y,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, x, y,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: x - y, one bit per clock, LSB first, through a
// single full-subtractor cell with a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sx_reg;
    logic [WIDTH-1:0] sy_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             bin_reg;
    logic             borrow_reg;
    logic             busy_reg;
    logic             done_reg;

    // Full-subtractor cell fed by the current LSBs and the carried borrow.
    logic a_bit, b_bit, d_bit, bout_bit;
    assign a_bit    = sx_reg[0];
    assign b_bit    = sy_reg[0];
    assign d_bit    = a_bit ^ b_bit ^ bin_reg;
    assign bout_bit = (~a_bit & (b_bit ^ bin_reg)) | (b_bit & bin_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sx_reg     <= '0;
            sy_reg     <= '0;
            sr_reg     <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            bin_reg    <= 1'b0;
            borrow_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                // DONE accepts a new request exactly like IDLE so ops can run back-to-back.
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        sx_reg    <= bus.x;
                        sy_reg    <= bus.y;
                        bin_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    sr_reg  <= {d_bit, sr_reg[WIDTH-1:1]};
                    sx_reg  <= sx_reg >> 1;
                    sy_reg  <= sy_reg >> 1;
                    bin_reg <= bout_bit;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        diff_reg   <= {d_bit, sr_reg[WIDTH-1:1]};
                        borrow_reg <= bout_bit;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.diff       = diff_reg;
    assign bus.borrow_out = borrow_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the serial subtractor at WIDTH=8, plus an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_diff;
    logic       last_borrow;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; pulse_at >= 0 injects a stray start (with junk operands) mid-SHIFT.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic eb, input int pulse_at, input string tag);
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = a; bus8.y = b;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus8.start = (i == pulse_at);
            if (i == pulse_at) begin
                bus8.x = 8'h01; bus8.y = 8'hFE;
            end
            check({tag, " busy"}, bus8.busy, 1);
            check({tag, " no_done"}, bus8.done, 0);
            check({tag, " diff_held"}, bus8.diff, last_diff);
        end
        @(negedge clk);
        check({tag, " done"}, bus8.done, 1);
        check({tag, " busy_low"}, bus8.busy, 0);
        check({tag, " diff"}, bus8.diff, ed);
        check({tag, " borrow"}, bus8.borrow_out, eb);
        last_diff = ed; last_borrow = eb;
        @(negedge clk);
        check({tag, " done_pulse_1cyc"}, bus8.done, 0);
        check({tag, " idle_busy"}, bus8.busy, 0);
        check({tag, " diff_stable"}, bus8.diff, ed);
        $display("op %s: x=%0d y=%0d diff=%0h borrow=%0b", tag, a, b, bus8.diff, bus8.borrow_out);
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.x = '0; bus8.y = '0;
        bus4.start = 1'b0; bus4.x = '0; bus4.y = '0;
        last_diff = '0; last_borrow = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", bus8.busy, 0);
        check("reset done", bus8.done, 0);
        check("reset diff", bus8.diff, 0);
        check("reset borrow", bus8.borrow_out, 0);
        rst = 1'b0;

        run8(8'd100, 8'd37,  8'h3F, 1'b0, -1, "100-37");
        run8(8'd37,  8'd100, 8'hC1, 1'b1, -1, "37-100");
        run8(8'd0,   8'd1,   8'hFF, 1'b1, -1, "0-1");
        run8(8'h5A,  8'h5A,  8'h00, 1'b0, -1, "5A-5A");
        run8(8'd100, 8'd37,  8'h3F, 1'b0, 2,  "ignore_start");

        // Start held high: DONE must chain straight into the next SHIFT.
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = 8'd200; bus8.y = 8'd55;
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("b2b busy", bus8.busy, 1);
                check("b2b no_done", bus8.done, 0);
            end
            @(negedge clk);
            check("b2b done", bus8.done, 1);
            check("b2b busy_low", bus8.busy, 0);
            check("b2b diff", bus8.diff, 8'd145);
            check("b2b borrow", bus8.borrow_out, 0);
            $display("op b2b[%0d]: x=200 y=55 diff=%0d borrow=%0b", op, bus8.diff, bus8.borrow_out);
            if (op == 2) bus8.start = 1'b0;
        end
        @(negedge clk);
        check("b2b end done", bus8.done, 0);
        check("b2b end busy", bus8.busy, 0);
        last_diff = 8'd145;

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = 8'd100; bus8.y = 8'd37;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus8.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst busy", bus8.busy, 0);
        check("async_rst done", bus8.done, 0);
        check("async_rst diff", bus8.diff, 0);
        check("async_rst borrow", bus8.borrow_out, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst no_done", bus8.done, 0);
        end
        rst = 1'b0;
        last_diff = '0;
        $display("op async_rst: outputs cleared mid-SHIFT");
        run8(8'd9, 8'd4, 8'd5, 1'b0, -1, "9-4");

        // Exhaustive sweep of the 4-bit instance.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] ed4;
                ed4 = 4'(a - b);
                @(negedge clk);
                bus4.start = 1'b1; bus4.x = 4'(a); bus4.y = 4'(b);
                @(negedge clk);
                bus4.start = 1'b0;
                repeat (3) @(negedge clk);
                @(negedge clk);
                check("w4 done", bus4.done, 1);
                check("w4 diff", bus4.diff, ed4);
                check("w4 borrow", bus4.borrow_out, (a < b) ? 1 : 0);
                $display("op w4: x=%0d y=%0d diff=%0d borrow=%0b", a, b, bus4.diff, bus4.borrow_out);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
